// File: rtl/systolic_pe_mac.sv
// systolic_pe_mac
// One processing element of an N x N output-stationary systolic array.
// Each cycle the PE multiplies its west and north operands and accumulates
// the product locally. Operands are forwarded east/south and the control
// strobes are delayed one cycle for the neighbouring PEs. When cal_done is
// sampled the accumulated result is published on a daisy-chained result bus
// that also carries results from upstream PEs (din -> dout).
//
// Ports:
//   clk         system clock, rising edge
//   sys_rst_n   asynchronous reset, ACTIVE HIGH despite the suffix
//   cal_en      operands valid this cycle, accumulate
//   cal_done    publish result and clear accumulator
//   westin      row operand from west neighbour      [IN_LEN]
//   northin     column operand from north neighbour  [IN_LEN]
//   din_val     upstream result valid
//   din         upstream result data                 [OUT_LEN]
//   n_cal_en    cal_en delayed one cycle
//   n_cal_done  cal_done delayed one cycle
//   eastout     westin registered, zero-extended     [OUT_LEN]
//   southout    northin registered, zero-extended    [OUT_LEN]
//   dout_val    result bus valid
//   dout        result bus data                      [OUT_LEN]
module systolic_pe_mac #(
  parameter int N       = 3,
  parameter int IN_LEN  = 8,
  parameter int OUT_LEN = 8
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               cal_en,
  input  logic               cal_done,
  input  logic [IN_LEN-1:0]  westin,
  input  logic [IN_LEN-1:0]  northin,
  input  logic               din_val,
  input  logic [OUT_LEN-1:0] din,
  output logic               n_cal_en,
  output logic               n_cal_done,
  output logic [OUT_LEN-1:0] eastout,
  output logic [OUT_LEN-1:0] southout,
  output logic               dout_val,
  output logic [OUT_LEN-1:0] dout
);

  logic [OUT_LEN-1:0] acc;
  logic               hold_val;
  logic [OUT_LEN-1:0] hold_data;

  logic [OUT_LEN-1:0] west_ext;
  logic [OUT_LEN-1:0] north_ext;
  logic [OUT_LEN-1:0] product;
  logic [OUT_LEN-1:0] acc_plus;
  logic [OUT_LEN-1:0] publish_val;

  // The accumulator wraps modulo 2^OUT_LEN, so only the low OUT_LEN bits of
  // the full product ever matter. Multiplying the zero-extended operands at
  // OUT_LEN width yields exactly those bits.
  always_comb begin
    west_ext    = OUT_LEN'(westin);
    north_ext   = OUT_LEN'(northin);
    product     = west_ext * north_ext;
    acc_plus    = acc + product;
    publish_val = cal_en ? acc_plus : acc;
  end

  // Operand forwarding and strobe delays run every cycle, independent of
  // cal_en, so the wavefront keeps moving through the array.
  always_ff @(posedge clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      n_cal_en   <= 1'b0;
      n_cal_done <= 1'b0;
      eastout    <= '0;
      southout   <= '0;
    end else begin
      n_cal_en   <= cal_en;
      n_cal_done <= cal_done;
      eastout    <= west_ext;
      southout   <= north_ext;
    end
  end

  // Accumulator: cal_done publishes (including a same-cycle product) and
  // clears, otherwise cal_en adds the product.
  always_ff @(posedge clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      acc <= '0;
    end else if (cal_done) begin
      acc <= '0;
    end else if (cal_en) begin
      acc <= acc_plus;
    end
  end

  // Result bus. Priority: own result, then a buffered upstream result, then
  // a fresh upstream result. An upstream result that loses arbitration is
  // parked in the one-entry holding register; when the buffer drains while a
  // new din arrives, that din takes its place. The array schedule never
  // produces a second collision while the buffer is full.
  always_ff @(posedge clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      dout      <= '0;
      dout_val  <= 1'b0;
      hold_val  <= 1'b0;
      hold_data <= '0;
    end else if (cal_done) begin
      dout     <= publish_val;
      dout_val <= 1'b1;
      if (din_val) begin
        hold_val  <= 1'b1;
        hold_data <= din;
      end
    end else if (hold_val) begin
      dout     <= hold_data;
      dout_val <= 1'b1;
      if (din_val) begin
        hold_data <= din;
      end else begin
        hold_val <= 1'b0;
      end
    end else if (din_val) begin
      dout     <= din;
      dout_val <= 1'b1;
    end else begin
      dout_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_pe_mac.sv
// tb_systolic_pe_mac
// Directed testbench for systolic_pe_mac. Stimulus pushes hand-computed
// expected result-bus words (with the cycle they are due) into a queue; a
// monitor on the falling edge pops and compares whenever dout_val is high,
// and flags results that never arrive or arrive unannounced.
module tb_systolic_pe_mac;

  localparam int IN_LEN  = 8;
  localparam int OUT_LEN = 8;

  logic               clk;
  logic               sys_rst_n;
  logic               cal_en;
  logic               cal_done;
  logic [IN_LEN-1:0]  westin;
  logic [IN_LEN-1:0]  northin;
  logic               din_val;
  logic [OUT_LEN-1:0] din;
  logic               n_cal_en;
  logic               n_cal_done;
  logic [OUT_LEN-1:0] eastout;
  logic [OUT_LEN-1:0] southout;
  logic               dout_val;
  logic [OUT_LEN-1:0] dout;

  typedef struct {
    logic [OUT_LEN-1:0] data;
    int                 due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   compared;
  int   mismatched;

  systolic_pe_mac #(.N(3), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .cal_en     (cal_en),
    .cal_done   (cal_done),
    .westin     (westin),
    .northin    (northin),
    .din_val    (din_val),
    .din        (din),
    .n_cal_en   (n_cal_en),
    .n_cal_done (n_cal_done),
    .eastout    (eastout),
    .southout   (southout),
    .dout_val   (dout_val),
    .dout       (dout)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to timestamp expected results
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs; returns 1 ns after the edge that samples them
  task automatic applyStimulus(input logic en, input logic done,
                               input int w, input int n,
                               input logic dv, input int d);
    cal_en   = en;
    cal_done = done;
    westin   = IN_LEN'(w);
    northin  = IN_LEN'(n);
    din_val  = dv;
    din      = OUT_LEN'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  // Expect a result-bus word lat cycles after the next edge's inputs are set
  task automatic expectResult(input int value, input int lat);
    exp_t e;
    e.data = OUT_LEN'(value);
    e.due  = cyc + lat;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: compares every presented result against the queue
  always @(negedge clk) begin
    if (!sys_rst_n) begin
      if (dout_val) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_dout_val", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("dout_data", int'(dout), int'(e.data));
          checkOutput("dout_cycle", cyc, e.due);
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("dout_missing", 0, int'(e.data) + 1000);
      end
    end
  end

  initial begin
    cyc        = 0;
    compared   = 0;
    mismatched = 0;
    sys_rst_n  = 1'b1;
    cal_en = 0; cal_done = 0; westin = 0; northin = 0; din_val = 0; din = 0;

    // Reset held for two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      cal_en   = 1'($urandom);
      cal_done = 1'($urandom);
      westin   = IN_LEN'($urandom);
      northin  = IN_LEN'($urandom);
      din_val  = 1'($urandom);
      din      = OUT_LEN'($urandom);
      @(posedge clk);
      #1;
      checkOutput("rst_dout_val", int'(dout_val), 0);
      checkOutput("rst_dout", int'(dout), 0);
      checkOutput("rst_eastout", int'(eastout), 0);
      checkOutput("rst_n_cal_en", int'(n_cal_en), 0);
    end
    cal_en = 0; cal_done = 0; westin = 0; northin = 0; din_val = 0; din = 0;
    sys_rst_n = 1'b0;
    idle();

    // Basic MAC: 2*2 + 3*3 + 4*4 = 29
    applyStimulus(1, 0, 2, 2, 0, 0);
    checkOutput("mac_east0", int'(eastout), 2);
    checkOutput("mac_ncalen0", int'(n_cal_en), 1);
    applyStimulus(1, 0, 3, 3, 0, 0);
    checkOutput("mac_south1", int'(southout), 3);
    applyStimulus(1, 0, 4, 4, 0, 0);
    checkOutput("mac_east2", int'(eastout), 4);
    expectResult(29, 1);
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkOutput("mac_east3", int'(eastout), 1);
    checkOutput("mac_ncalen3", int'(n_cal_en), 0);
    checkOutput("mac_ncaldone3", int'(n_cal_done), 1);
    idle();
    checkOutput("mac_ncaldone4", int'(n_cal_done), 0);

    // Forwarding of an upstream result
    expectResult(10, 1);
    applyStimulus(0, 0, 0, 0, 1, 10);
    idle();
    idle();
    checkOutput("fwd_hold_dout", int'(dout), 10);

    // Collision: own result 5 wins, din 7 follows
    applyStimulus(1, 0, 1, 5, 0, 0);
    expectResult(5, 1);
    expectResult(7, 2);
    applyStimulus(0, 1, 0, 0, 1, 7);
    idle();
    idle();

    // Full buffer beats a new din, which is then buffered itself
    applyStimulus(1, 0, 2, 2, 0, 0);
    expectResult(4, 1);
    expectResult(20, 2);
    expectResult(30, 3);
    applyStimulus(0, 1, 0, 0, 1, 20);
    applyStimulus(0, 0, 0, 0, 1, 30);
    idle();
    idle();

    // Wrap: 2*65025 mod 256 = 2, then back-to-back 1*1 = 1
    applyStimulus(1, 0, 255, 255, 0, 0);
    applyStimulus(1, 0, 255, 255, 0, 0);
    checkOutput("wrap_east", int'(eastout), 255);
    expectResult(2, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 0);
    expectResult(1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idle();

    // Simultaneous cal_en + cal_done: 6 + 3*3 = 15
    applyStimulus(1, 0, 2, 3, 0, 0);
    expectResult(15, 1);
    applyStimulus(1, 1, 3, 3, 0, 0);
    idle();

    // cal_done with no preceding cal_en publishes 0
    expectResult(0, 1);
    applyStimulus(0, 1, 7, 7, 0, 0);
    idle();

    // Reset mid-accumulation clears outputs at once and drops the partial sum
    applyStimulus(1, 0, 5, 5, 0, 0);
    applyStimulus(1, 0, 5, 5, 0, 0);
    #2;
    sys_rst_n = 1'b1;
    #1;
    checkOutput("midrst_eastout", int'(eastout), 0);
    checkOutput("midrst_southout", int'(southout), 0);
    checkOutput("midrst_n_cal_en", int'(n_cal_en), 0);
    checkOutput("midrst_dout", int'(dout), 0);
    cal_en = 0; westin = 0; northin = 0;
    @(posedge clk);
    #1;
    sys_rst_n = 1'b0;
    applyStimulus(1, 0, 1, 2, 0, 0);
    expectResult(2, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idle();
    idle();
    idle();

    // Anything still queued never appeared on the bus
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checkOutput("dout_never_seen", 0, int'(e.data) + 1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/systolic_pe_mac.md
Name: systolic_pe_mac

Overview:
- One processing element (PE) of an N x N output-stationary systolic array for matrix multiply.
- Each cycle the PE multiplies its west and north operands and adds the product into a local accumulator.
- It forwards the operands east and south, and delays the control strobes by one cycle for the neighbouring PEs.
- On cal_done it publishes its result on a daisy-chained result bus (din -> dout), which also carries results from upstream PEs.

Parameters:
- N, 3: array dimension. No effect on the single-PE datapath; kept so all PEs instantiate uniformly.
- IN_LEN, 8: operand width (westin, northin).
- OUT_LEN, 8: accumulator, result-bus and forwarded-operand width.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- sys_rst_n  in  1  asynchronous, active-high reset. 1 = reset, despite the suffix.
- cal_en  in  1  accumulate strobe: the operands are valid this cycle.
- cal_done  in  1  end of computation: publish the result and clear the accumulator.
- westin  in  IN_LEN  row operand from the west neighbour.
- northin  in  IN_LEN  column operand from the north neighbour.
- din_val  in  1  upstream result valid.
- din  in  OUT_LEN  upstream result data.
- n_cal_en  out  1  cal_en delayed one cycle, for the next PE.
- n_cal_done  out  1  cal_done delayed one cycle.
- eastout  out  OUT_LEN  westin registered, zero-extended.
- southout  out  OUT_LEN  northin registered, zero-extended.
- dout_val  out  1  result-bus valid.
- dout  out  OUT_LEN  result-bus data.

Behaviour:
- Reset: asserting sys_rst_n=1 immediately clears every output, the accumulator and the holding buffer to 0. Reset mid-computation discards the partial sum and any pending result.
- Arithmetic is unsigned. Product = westin*northin, full 2*IN_LEN bits. Accumulation is modulo 2^OUT_LEN; overflow wraps with no flag.
- Accumulate: on a rising edge with cal_en=1 and cal_done=0, acc <= acc + product.
- Publish: on a rising edge with cal_done=1:
  - dout <= acc + (cal_en ? product : 0);
  - dout_val <= 1;
  - acc <= 0.
- Own result is valid for exactly one cycle (latency 1 from the sampled cal_done).
- Forwarding: on an edge with din_val=1 and no publish that cycle, dout <= din and dout_val <= 1 (latency 1).
- Collision (din_val=1 and cal_done=1 on the same edge):
  - the own result wins;
  - din is captured in a one-entry holding register and emitted the following cycle with dout_val=1.
  - Array scheduling guarantees a second collision never occurs while the buffer is full.
- A full holding buffer takes priority over a new din in the next cycle. A simultaneous new din is then buffered in turn.
- Idle (no publish, no din_val, buffer empty): dout_val <= 0 and dout holds its last value.
- eastout/southout: register westin/northin every cycle regardless of cal_en; the upper OUT_LEN-IN_LEN bits are 0.
- n_cal_en/n_cal_done: register cal_en/cal_done every cycle.
- cal_done with no preceding cal_en publishes 0 with dout_val=1.

Test Plan:
- Reset: hold sys_rst_n=1 for 2 cycles with random inputs -> all outputs 0. Pulse reset mid-accumulation -> outputs clear immediately and the next result excludes pre-reset terms.
- Basic MAC: cal_en for 3 cycles with westin=northin=2,3,4, then cal_done for 1 cycle -> dout=29, dout_val=1 for exactly one cycle, one cycle after cal_done is sampled. n_cal_en is high 3 cycles, delayed one cycle; eastout/southout follow 2,3,4,1 one cycle late.
- Forwarding: after the publish, din_val=1 with din=10 for one cycle -> next cycle dout=10 and dout_val=1, then dout_val=0.
- Collision: cal_done and din_val=1 (din=7) on the same edge with acc=5 -> dout=5 then dout=7 on consecutive cycles, dout_val high for both.
- Wrap and back-to-back: westin=northin=255 for 2 cycles, then cal_done -> dout=(2*65025) mod 256=2. A new cal_en/cal_done sequence (1*1, then done) -> dout=1, proving the accumulator was cleared.
- Simultaneous cal_en+cal_done with acc=6, operands 3,3 -> dout=15.
